// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader
//   Read-side master for a block-RAM dual-port buffer. A frame is a start
//   address plus a word count. The block issues reads on the RAM read port,
//   absorbs the RAM's one-cycle registered read latency with a 2-entry
//   buffer, and streams the words out in address order as valid/ready with an
//   end-of-frame marker.
//
// Ports
//   clk         clock, shared with the RAM read port (clkb)
//   resetn      synchronous active-low reset
//   start       one-cycle frame request, only honoured while idle
//   start_addr  first RAM address (sampled with start)
//   length      words to read (sampled with start), saturates at RAM depth
//   busy        frame in progress (RUN or FINISH)
//   done        one-cycle pulse after the final word is accepted
//   ram_reb     RAM read enable
//   ram_addrb   RAM read address, wraps past the top of the RAM
//   ram_doutb   RAM read data, valid the cycle after ram_reb
//   m_valid     stream word valid
//   m_ready     downstream accept
//   m_data      stream word
//   m_last      final word of the frame
//   dbg_state   FSM state (0 IDLE, 1 RUN, 2 FINISH)
//
// Handshake: a word transfers on a rising clk edge where m_valid & m_ready.
// m_valid is a pure function of registered state (never of m_ready); once
// raised it stays high, with m_data/m_last stable, until the word transfers.
module dpram_stream_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_reb,
  output logic [ADDRESS_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0]    ram_doutb,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  localparam logic [ADDRESS_WIDTH:0] MAX_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE     = (ADDRESS_WIDTH+1)'(1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [ADDRESS_WIDTH:0]   len_q;
  logic [ADDRESS_WIDTH:0]   issued_q;
  logic [ADDRESS_WIDTH:0]   accepted_q;
  logic                     inflight_q;
  logic [DATA_WIDTH-1:0]    buf_q [2];
  logic                     rd_ptr_q, wr_ptr_q;
  logic [1:0]               count_q;

  logic                     pop, push, words_left, frame_go;
  logic [2:0]               occ;

  assign m_valid    = (count_q != 2'd0);
  assign m_data     = buf_q[rd_ptr_q];
  assign m_last     = m_valid && (accepted_q == (len_q - ONE));
  assign pop        = m_valid & m_ready;
  assign push       = inflight_q;
  assign words_left = (issued_q != len_q);
  assign frame_go   = (state_q == S_IDLE) && start && (length != '0);
  // The address is derived from the issue count; after a frame the count
  // stays put, so the address holds while idle.
  assign ram_addrb  = base_q + issued_q[ADDRESS_WIDTH-1:0];
  // Buffered words plus the read in flight, minus the word leaving this
  // cycle; a new read is allowed only if its data will find a free slot.
  assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (length == '0) ? S_FINISH : S_RUN;
      S_RUN:    if (pop && m_last) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FINISH);
    ram_reb   = (state_q == S_RUN) && words_left && (occ < 3'd2);
    dbg_state = state_q;
  end

  // Frame bookkeeping and output buffer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (frame_go) begin
        base_q     <= start_addr;
        len_q      <= (length > MAX_LEN) ? MAX_LEN : length;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (ram_reb) issued_q   <= issued_q + ONE;
        if (pop)     accepted_q <= accepted_q + ONE;
      end
      // ram_doutb is only meaningful the cycle after a read enable.
      inflight_q <= ram_reb;
      if (push) begin
        buf_q[wr_ptr_q] <= ram_doutb;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Testbench for dpram_stream_reader: a behavioural RAM read port preloaded
// with mem[i] = 0x100 + i, directed frames, and a queue-based scoreboard
// checked by an independent monitor on the falling clock edge.
module tb_dpram_stream_reader;
  localparam int DW = 16;
  localparam int AW = 5;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_reb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [1:0]    dbg_state;

  dpram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_reb    (ram_reb),
    .ram_addrb  (ram_addrb),
    .ram_doutb  (ram_doutb),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .dbg_state  (dbg_state)
  );

  // RAM read port: registered read; junk when not enabled
  logic [DW-1:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = DW'(16'h100 + i);
  always @(posedge clk) ram_doutb <= ram_reb ? mem[ram_addrb] : DW'($urandom);

  // Downstream ready driver
  int   cyc = 0;
  logic ready_en = 1'b1;
  int   ready_mode = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_ready = ready_en && ((ready_mode == 0) || pat[cyc % 6]);
    end
  end

  // Scoreboard
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor
  int          issued_n = 0, popped_n = 0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic        prev_last;
  initial begin
    logic [DW:0]   e;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      if (ram_reb) begin
        if (addr_q.size() == 0) check("unexpected_reb", 32'(ram_addrb), 32'hFFFF);
        else begin
          ea = addr_q.pop_front();
          check("ram_addrb", 32'(ram_addrb), 32'(ea));
        end
        issued_n++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(m_data), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e[DW-1:0]));
          check("m_last", 32'(m_last), 32'(e[DW]));
        end
        popped_n++;
      end
      if (ram_reb) check("occupancy_le_2", 32'((issued_n - popped_n) <= 2), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
        check("stall_last", 32'(m_last), 32'(prev_last));
      end
      prev_stall = resetn && m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (!resetn) begin
        issued_n = 0;
        popped_n = 0;
      end
    end
  end

  // Driver tasks
  task automatic expect_word(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic last);
    addr_q.push_back(ad);
    exp_q.push_back({last, d});
  endtask

  task automatic expect_frame(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = a + AW'(i);
      expect_word(ad, DW'(16'h100) + DW'(ad), i == n - 1);
    end
  endtask

  // exp_first: -2 skip, -1 no m_valid expected; exp_done: <0 skip.
  task automatic run_frame(input logic [AW-1:0] a, input logic [AW:0] len,
                           input int exp_first, input int exp_done, input int restart_idx);
    int   first, done_idx, idx;
    logic busy_ok;
    first = -1; done_idx = -1; busy_ok = 1'b1; idx = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = len;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < 400 && done_idx < 0) begin
      @(negedge clk);
      if (m_valid && first < 0) first = idx;
      if (!busy) busy_ok = 1'b0;
      if (done) done_idx = idx;
      if (idx == restart_idx) begin
        start = 1'b1; start_addr = a + AW'(10); length = 6'd2;
      end else start = 1'b0;
      idx++;
    end
    start = 1'b0;
    check("done_seen", 32'(done_idx >= 0), 32'd1);
    check("busy_through_frame", 32'(busy_ok), 32'd1);
    if (exp_first != -2) check("first_valid_cycle", 32'(first), 32'(exp_first));
    if (exp_done >= 0) check("done_cycle", 32'(done_idx), 32'(exp_done));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("addr_drained", 32'(addr_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ram_reb"}, 32'(ram_reb), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
    check({tag, "_ram_addrb"}, 32'(ram_addrb), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
  endtask

  // Main sequence
  initial begin
    int   acc;
    logic quiet_ok;
    resetn = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Basic frame, ready held high
    ready_mode = 0;
    expect_word(5'd3, 16'h103, 1'b0);
    expect_word(5'd4, 16'h104, 1'b0);
    expect_word(5'd5, 16'h105, 1'b0);
    expect_word(5'd6, 16'h106, 1'b1);
    run_frame(5'd3, 6'd4, 2, 6, -1);

    // Same frame with ready toggling
    ready_mode = 1;
    expect_word(5'd3, 16'h103, 1'b0);
    expect_word(5'd4, 16'h104, 1'b0);
    expect_word(5'd5, 16'h105, 1'b0);
    expect_word(5'd6, 16'h106, 1'b1);
    run_frame(5'd3, 6'd4, 2, -1, -1);
    ready_mode = 0;

    // Address wrap
    expect_word(5'd30, 16'h11E, 1'b0);
    expect_word(5'd31, 16'h11F, 1'b0);
    expect_word(5'd0,  16'h100, 1'b0);
    expect_word(5'd1,  16'h101, 1'b1);
    run_frame(5'd30, 6'd4, 2, 6, -1);

    // Zero length: done in the cycle after start, nothing streamed
    run_frame(5'd7, 6'd0, -1, 0, -1);

    // Length saturation: 40 -> 32 words
    expect_frame(5'd0, 32);
    run_frame(5'd0, 6'd40, 2, 34, -1);

    // Start pulsed mid-frame is ignored
    expect_frame(5'd3, 4);
    run_frame(5'd3, 6'd4, 2, 6, 1);

    // Reset after 2 of 8 words accepted
    expect_frame(5'd0, 8);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 5'd0; length = 6'd8;
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0;
    for (int i = 0; i < 50 && acc < 2; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) acc++;
    end
    check("reset_test_two_accepted", 32'(acc), 32'd2);
    ready_en = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    quiet_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy || m_valid || ram_reb) quiet_ok = 1'b0;
    end
    check("no_done_after_reset", 32'(quiet_ok), 32'd1);
    ready_en = 1'b1;
    @(posedge clk);
    expect_frame(5'd0, 8);
    run_frame(5'd0, 6'd8, 2, 10, -1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Read-side master for the block-RAM dual-port memory.
- Takes a start address and a word count, and issues read enables and addresses on the RAM read port.
- Absorbs the RAM's one-cycle registered read latency and presents the words as a valid/ready stream with an end-of-frame marker.
- Sits between a RAM buffer (filled by the capture path on the write port) and downstream DSP or DMA logic. Same clock as RAM read port clkb.

Parameters:
- DATA_WIDTH, 16, word width; must match the RAM.
- ADDRESS_WIDTH, 5, RAM address width; RAM depth is 2**ADDRESS_WIDTH.

Ports:
- clk  input  1  clock; also drives RAM clkb.
- resetn  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a frame; ignored unless idle.
- start_addr  input  ADDRESS_WIDTH  first RAM address, sampled with start.
- length  input  ADDRESS_WIDTH+1  words to read, sampled with start.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame completion.
- ram_reb  output  1  RAM read enable.
- ram_addrb  output  ADDRESS_WIDTH  RAM read address.
- ram_doutb  input  DATA_WIDTH  RAM read data, valid the cycle after ram_reb.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  marks the final word of the frame.

Behaviour:
- Reset (resetn=0 at a clk edge) is synchronous and clears everything:
  - busy, done, ram_reb, m_valid and m_last = 0; ram_addrb = 0; m_data = 0.
  - Issue/receive counters cleared, 2-entry output buffer emptied, in-flight read discarded, state IDLE.
  - Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, RUN, FINISH.
  - IDLE:
    - start=1 with length=0 -> FINISH; no RAM reads.
    - start=1 with length>0 -> RUN. Latch start_addr and length; length values above 2**ADDRESS_WIDTH saturate to 2**ADDRESS_WIDTH.
    - start=0 -> stay in IDLE.
  - RUN: issue reads and drain the buffer. Move to FINISH at the edge where the final word (m_last=1) is accepted (m_valid & m_ready).
  - FINISH: done=1 for exactly one cycle, then IDLE.
  - busy=1 in RUN and FINISH. start during busy is ignored.
- Read issue:
  - ram_reb=1 in a RUN cycle iff words remain to issue and (buffer occupancy + in-flight reads − (m_valid & m_ready)) < 2.
  - ram_addrb = latched start address plus issued count, modulo 2**ADDRESS_WIDTH, so the address wraps past the top of the RAM to 0.
  - ram_reb is 0 in IDLE and FINISH; ram_addrb holds its last value.
- Capture: in the cycle after each ram_reb=1, ram_doutb is written into the 2-entry FIFO buffer at the clock edge. ram_doutb is never sampled in other cycles.
- Latency:
  - start sampled at edge E0 -> ram_reb=1 during cycle E0..E1.
  - Data captured at E2; m_valid=1 from E2.
  - With m_ready held at 1, the stream runs one word per clk with no bubbles.
- Stream rules:
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid stays 1.
  - m_valid never depends combinationally on m_ready.
  - Words leave in address order. m_last=1 only on word length−1.
- done is asserted in the cycle after the final handshake; a length=0 frame pulses done in the cycle after start.
- A new start is accepted the cycle after done, when the block is back in IDLE.

Test Plan:
- ADDRESS_WIDTH=5, RAM preloaded with mem[i]=0x100+i, start_addr=3, length=4, m_ready=1:
  - ram_addrb 3,4,5,6 on consecutive cycles.
  - m_data 0x103..0x106 on 4 consecutive cycles, first m_valid 2 cycles after the start edge.
  - m_last on 0x106; done one cycle later; busy high from start+1 through done.
- Same frame with m_ready toggling 1,0,0,1,0,1...:
  - Every word delivered exactly once, in order, held stable while stalled.
  - Occupancy plus in-flight never exceeds 2; ram_reb pauses while the buffer is full.
- Wrap: start_addr=30, length=4 -> addresses 30,31,0,1; data 0x11E,0x11F,0x100,0x101.
- length=0 -> no ram_reb, no m_valid, done pulse the cycle after start. length=40 -> saturates to 32 words, m_last on the 32nd.
- start pulsed again mid-frame with a different address -> ignored; the original frame completes unchanged.
- resetn=0 for one cycle after 2 of 8 words accepted:
  - Next cycle all outputs are 0 and no done pulse occurs.
  - A subsequent start runs a clean full frame.
